// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush/redirect controller for N pipeline registers: stalls, load-use bubbles, pending redirects.
// Optional interrupt redirect is compiled in when PIPE_CTRL_IRQ_EN is defined.
module pipe_hold_ctrl #(
  parameter int ADDR_W     = 64,
  parameter int NUM_STAGES = 5,
  parameter int BR_STAGE   = 1,
  parameter int MEM_STAGE  = 3,
  parameter int LU_BUBBLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_if,
  input  logic                  stall_mem,
  input  logic                  load_use,
  input  logic                  br_valid,
  input  logic [ADDR_W-1:0]     br_target,
  input  logic [ADDR_W-1:0]     pc_pred,
  input  logic                  irq_req,
  input  logic [ADDR_W-1:0]     irq_vec,
  output logic [NUM_STAGES-1:0] hold_vec,
  output logic [NUM_STAGES-1:0] flush_vec,
  output logic                  redirect_valid,
  output logic [ADDR_W-1:0]     redirect_pc,
  output logic                  instr_mask,
  output logic                  irq_ack
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LU_HOLD    = 2'd1,
    REDIR_PEND = 2'd2
  } state_t;

  function automatic logic [NUM_STAGES-1:0] stage_range(input int lo, input int hi);
    logic [NUM_STAGES-1:0] m;
    m = {NUM_STAGES{1'b0}};
    for (int i = 0; i < NUM_STAGES; i++) begin
      if ((i >= lo) && (i <= hi)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  localparam logic [NUM_STAGES-1:0] PC_MASK   = stage_range(0, 0);
  localparam logic [NUM_STAGES-1:0] IFID_MASK = stage_range(1, 1);
  localparam logic [NUM_STAGES-1:0] BR_FLUSH  = stage_range(1, BR_STAGE);
  localparam logic [NUM_STAGES-1:0] LU_HOLDM  = stage_range(0, BR_STAGE);
  localparam logic [NUM_STAGES-1:0] LU_FLUSH  = stage_range(BR_STAGE + 1, BR_STAGE + 1);
  localparam logic [NUM_STAGES-1:0] MEM_HOLD  = stage_range(0, MEM_STAGE);
  localparam logic [NUM_STAGES-1:0] MEM_FLUSH = stage_range(MEM_STAGE + 1, MEM_STAGE + 1);
  localparam logic [NUM_STAGES-1:0] IRQ_FLUSH = stage_range(1, MEM_STAGE);
  localparam logic [NUM_STAGES-1:0] ALL_MASK  = {NUM_STAGES{1'b1}};
  localparam logic [2:0]            LU_INIT   = 3'(LU_BUBBLES - 1);

  state_t              state_r, state_nxt_s;
  logic [2:0]          lu_cnt_r, lu_cnt_nxt_s;
  logic [ADDR_W-1:0]   pend_pc_r, pend_pc_nxt_s;
  logic                mispredict_s;
  logic                irq_en_s;
  logic [ADDR_W-1:0]   irq_pc_s;

  assign mispredict_s = br_valid & (br_target != pc_pred);

`ifdef PIPE_CTRL_IRQ_EN
  assign irq_en_s = irq_req;
  assign irq_pc_s = irq_vec;
`else
  logic unused_irq_s;
  assign unused_irq_s = irq_req ^ (^irq_vec);
  assign irq_en_s     = 1'b0;
  assign irq_pc_s     = {ADDR_W{1'b0}};
`endif

  // State, bubble counter and pending redirect target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RUN;
      lu_cnt_r  <= 3'd0;
      pend_pc_r <= {ADDR_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      lu_cnt_r  <= lu_cnt_nxt_s;
      pend_pc_r <= pend_pc_nxt_s;
    end
  end

  // Next-state and per-cycle hold/flush/redirect decode in priority order.
  always_comb begin
    state_nxt_s    = state_r;
    lu_cnt_nxt_s   = lu_cnt_r;
    pend_pc_nxt_s  = pend_pc_r;
    hold_vec       = {NUM_STAGES{1'b0}};
    flush_vec      = {NUM_STAGES{1'b0}};
    redirect_valid = 1'b0;
    redirect_pc    = {ADDR_W{1'b0}};
    instr_mask     = 1'b0;
    irq_ack        = 1'b0;

    if (rst) begin
      flush_vec  = ALL_MASK;
      instr_mask = 1'b1;
    end else if (stall_mem) begin
      // Everything up to memory waits; state and counter stay frozen.
      hold_vec  = MEM_HOLD;
      flush_vec = MEM_FLUSH;
    end else begin
      case (state_r)
        RUN, LU_HOLD: begin
          if (mispredict_s) begin
            flush_vec    = BR_FLUSH;
            lu_cnt_nxt_s = 3'd0;
            if (stall_if) begin
              hold_vec      = PC_MASK;
              pend_pc_nxt_s = br_target;
              state_nxt_s   = REDIR_PEND;
            end else begin
              redirect_valid = 1'b1;
              redirect_pc    = br_target;
              state_nxt_s    = RUN;
            end
          end else if (state_r == LU_HOLD) begin
            hold_vec  = LU_HOLDM;
            flush_vec = LU_FLUSH;
            if (lu_cnt_r > 3'd1) begin
              lu_cnt_nxt_s = lu_cnt_r - 3'd1;
              state_nxt_s  = LU_HOLD;
            end else begin
              lu_cnt_nxt_s = 3'd0;
              state_nxt_s  = RUN;
            end
          end else if (load_use) begin
            hold_vec     = LU_HOLDM;
            flush_vec    = LU_FLUSH;
            lu_cnt_nxt_s = LU_INIT;
            if (LU_INIT != 3'd0) begin
              state_nxt_s = LU_HOLD;
            end else begin
              state_nxt_s = RUN;
            end
          end else if (stall_if) begin
            hold_vec  = PC_MASK;
            flush_vec = IFID_MASK;
          end else if (irq_en_s) begin
            irq_ack        = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = irq_pc_s;
            flush_vec      = IRQ_FLUSH;
          end else begin
            state_nxt_s = RUN;
          end
        end
        REDIR_PEND: begin
          if (stall_if) begin
            hold_vec  = PC_MASK;
            flush_vec = IFID_MASK;
          end else begin
            // The instruction arriving now belongs to the wrong path.
            instr_mask     = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = pend_pc_r;
            state_nxt_s    = RUN;
          end
        end
        default: begin
          state_nxt_s  = RUN;
          lu_cnt_nxt_s = 3'd0;
        end
      endcase
    end
  end

endmodule
